// File: rtl/cv32e41s_pkg.sv
// rtl/cv32e41s_pkg.sv - shared PMP/PMR types, CSR addresses and cfg legalisation
package cv32e41s_pkg;

  localparam int PMP_MAX_REGIONS = 16;

  localparam logic [1:0] PMP_MODE_OFF   = 2'b00;
  localparam logic [1:0] PMP_MODE_TOR   = 2'b01;
  localparam logic [1:0] PMP_MODE_NA4   = 2'b10;
  localparam logic [1:0] PMP_MODE_NAPOT = 2'b11;

  localparam logic [11:0] CSR_PMPCFG0     = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0    = 12'h3B0;
  localparam logic [11:0] CSR_PMRADDROFF0 = 12'hBC0;
  localparam logic [11:0] CSR_MSECCFG     = 12'h747;

  localparam int MSECCFG_MML_BIT  = 0;
  localparam int MSECCFG_MMWP_BIT = 1;
  localparam int MSECCFG_RLB_BIT  = 2;

  typedef enum logic [0:0] {
    PMR_EN_NONE = 1'b0,
    PMR_EN_ALL  = 1'b1
  } pmr_en_e;

  typedef enum logic [0:0] {
    CTRL_IDLE   = 1'b0,
    CTRL_COMMIT = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic       lock;
    logic [1:0] reserved;
    logic [1:0] mode;
    logic       exec;
    logic       write;
    logic       read;
  } pmpncfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } mseccfg_t;

  typedef struct packed {
    pmpncfg_t [PMP_MAX_REGIONS-1:0]        cfg;
    logic     [PMP_MAX_REGIONS-1:0][31:0]  addr;
    logic     [PMP_MAX_REGIONS-1:0][31:0]  pmraddroff;
    mseccfg_t                              mseccfg;
  } pmp_csr_t;

  // Returns the old byte whenever the write must be dropped as a whole.
  function automatic pmpncfg_t pmpcfg_legalize(pmpncfg_t old_cfg, logic [7:0] wr_byte,
                                               logic mml, logic rlb, logic locked, int g);
    pmpncfg_t n;
    logic     shared;
    n      = pmpncfg_t'(wr_byte);
    shared = !n.read && n.write;
    if (locked || (shared && !mml) || (mml && !rlb && n.lock && n.exec && !shared)) begin
      n = old_cfg;
    end else begin
      n.reserved = 2'b00;
      if (g >= 1 && n.mode == PMP_MODE_NA4) n.mode = PMP_MODE_OFF;
    end
    return n;
  endfunction

endpackage

// File: rtl/cv32e41s_pmp_csr_ctrl_if.sv
// rtl/cv32e41s_pmp_csr_ctrl_if.sv - CSR write request/response bus
interface cv32e41s_pmp_csr_ctrl_if;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [11:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic        wr_done_o;
  logic        wr_err_o;

  modport master (output wr_valid_i, wr_addr_i, wr_data_i,
                  input  wr_ready_o, wr_done_o, wr_err_o);
  modport slave  (input  wr_valid_i, wr_addr_i, wr_data_i,
                  output wr_ready_o, wr_done_o, wr_err_o);
endinterface

// File: rtl/cv32e41s_pmp_cfg_legalizer.sv
// rtl/cv32e41s_pmp_cfg_legalizer.sv - WARL legalisation of one pmpcfg byte
module cv32e41s_pmp_cfg_legalizer
  import cv32e41s_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0
) (
  input  pmpncfg_t   old_cfg_i,
  input  logic [7:0] wr_byte_i,
  input  logic       mml_i,
  input  logic       rlb_i,
  input  logic       locked_i,
  output pmpncfg_t   cfg_o
);
  assign cfg_o = pmpcfg_legalize(old_cfg_i, wr_byte_i, mml_i, rlb_i, locked_i, PMP_GRANULARITY);
endmodule

// File: rtl/cv32e41s_pmp_csr_ctrl.sv
// rtl/cv32e41s_pmp_csr_ctrl.sv - PMP/PMR CSR owner: write commit FSM, lock rules, read-back
module cv32e41s_pmp_csr_ctrl
  import cv32e41s_pkg::*;
#(
  parameter int      PMP_NUM_REGIONS = 16,
  parameter int      PMP_GRANULARITY = 0,
  parameter pmr_en_e PMR_ENABLE      = PMR_EN_NONE
) (
  input  logic                    clk,
  input  logic                    rst,
  cv32e41s_pmp_csr_ctrl_if.slave  wr_bus,
  input  logic [11:0]             rd_addr_i,
  output logic [31:0]             rd_data_o,
  output pmp_csr_t                csr_pmp_o,
  output logic                    any_locked_o
);

  localparam logic [4:0]  NUM_REGIONS = 5'(PMP_NUM_REGIONS);
  localparam logic [31:0] NAPOT_ONES  = ((32'd1 << PMP_GRANULARITY) - 32'd1) >> 1;
  localparam logic [31:0] TOR_ZEROS   = (32'd1 << PMP_GRANULARITY) - 32'd1;

  ctrl_state_e              state_q, state_d;
  logic [11:0]              addr_q;
  logic [31:0]              data_q;
  pmpncfg_t [15:0]          cfg_q, cfg_d;
  logic     [15:0][31:0]    paddr_q, paddr_d, pmr_q, pmr_d;
  mseccfg_t                 msec_q, msec_d;
  pmpncfg_t [3:0]           leg_cfg;
  logic     [15:0]          locked, addr_ro;
  logic                     hit_cfg, hit_addr, hit_pmr, hit_msec;
  logic     [31:0]          addr_view;

  function automatic logic implemented(logic [3:0] idx);
    return {1'b0, idx} < NUM_REGIONS;
  endfunction

  assign hit_cfg  = addr_q[11:2] == CSR_PMPCFG0[11:2];
  assign hit_addr = addr_q[11:4] == CSR_PMPADDR0[11:4];
  assign hit_pmr  = addr_q[11:4] == CSR_PMRADDROFF0[11:4];
  assign hit_msec = addr_q == CSR_MSECCFG;

  // pmpaddr[i] is also frozen when the entry above uses it as a locked TOR base.
  always_comb begin
    any_locked_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      locked[i]    = cfg_q[i].lock && !msec_q.rlb;
      any_locked_o = any_locked_o | cfg_q[i].lock;
    end
    addr_ro = locked;
    for (int i = 0; i < 15; i++) begin
      if (cfg_q[i+1].lock && cfg_q[i+1].mode == PMP_MODE_TOR && !msec_q.rlb) addr_ro[i] = 1'b1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [3:0] idx;
    assign idx = {addr_q[1:0], 2'(k)};
    cv32e41s_pmp_cfg_legalizer #(.PMP_GRANULARITY(PMP_GRANULARITY)) u_legalizer (
      .old_cfg_i (cfg_q[idx]),
      .wr_byte_i (data_q[8*k +: 8]),
      .mml_i     (msec_q.mml),
      .rlb_i     (msec_q.rlb),
      .locked_i  (locked[idx]),
      .cfg_o     (leg_cfg[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CTRL_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
      paddr_q <= '0;
      pmr_q   <= '0;
      msec_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      paddr_q <= paddr_d;
      pmr_q   <= pmr_d;
      msec_q  <= msec_d;
      if (wr_bus.wr_valid_i && wr_bus.wr_ready_o) begin
        addr_q <= wr_bus.wr_addr_i;
        data_q <= wr_bus.wr_data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE:   if (wr_bus.wr_valid_i) state_d = CTRL_COMMIT;
      CTRL_COMMIT: state_d = CTRL_IDLE;
      default:     state_d = CTRL_IDLE;
    endcase
  end

  always_comb begin
    wr_bus.wr_ready_o = (state_q == CTRL_IDLE) && !rst;
    wr_bus.wr_done_o  = (state_q == CTRL_COMMIT) && !rst;
    wr_bus.wr_err_o   = wr_bus.wr_done_o && !(hit_cfg || hit_addr || hit_pmr || hit_msec);
  end

  // Register next-state; all lock checks see the pre-write register values.
  always_comb begin
    cfg_d   = cfg_q;
    paddr_d = paddr_q;
    pmr_d   = pmr_q;
    msec_d  = msec_q;
    if (state_q == CTRL_COMMIT) begin
      if (hit_cfg) begin
        for (int k = 0; k < 4; k++) begin
          if (implemented({addr_q[1:0], 2'(k)})) cfg_d[{addr_q[1:0], 2'(k)}] = leg_cfg[k];
        end
      end
      if (hit_addr && implemented(addr_q[3:0]) && !addr_ro[addr_q[3:0]]) begin
        paddr_d[addr_q[3:0]] = data_q;
      end
      if (hit_pmr && PMR_ENABLE != PMR_EN_NONE && implemented(addr_q[3:0]) && !locked[addr_q[3:0]]) begin
        pmr_d[addr_q[3:0]] = data_q;
      end
      if (hit_msec) begin
        msec_d.mml  = msec_q.mml  | data_q[MSECCFG_MML_BIT];
        msec_d.mmwp = msec_q.mmwp | data_q[MSECCFG_MMWP_BIT];
        msec_d.rlb  = data_q[MSECCFG_RLB_BIT] && (msec_q.rlb || !any_locked_o);
      end
    end
  end

  always_comb begin
    addr_view = paddr_q[rd_addr_i[3:0]];
    if (cfg_q[rd_addr_i[3:0]].mode == PMP_MODE_NAPOT) addr_view = addr_view | NAPOT_ONES;
    else if (!cfg_q[rd_addr_i[3:0]].mode[1])          addr_view = addr_view & ~TOR_ZEROS;
    rd_data_o = '0;
    if (rd_addr_i[11:2] == CSR_PMPCFG0[11:2]) begin
      rd_data_o = {cfg_q[{rd_addr_i[1:0], 2'd3}], cfg_q[{rd_addr_i[1:0], 2'd2}],
                   cfg_q[{rd_addr_i[1:0], 2'd1}], cfg_q[{rd_addr_i[1:0], 2'd0}]};
    end else if (rd_addr_i[11:4] == CSR_PMPADDR0[11:4]) begin
      rd_data_o = addr_view;
    end else if (rd_addr_i[11:4] == CSR_PMRADDROFF0[11:4]) begin
      rd_data_o = pmr_q[rd_addr_i[3:0]];
    end else if (rd_addr_i == CSR_MSECCFG) begin
      rd_data_o = {29'd0, msec_q};
    end
  end

  assign csr_pmp_o = '{cfg: cfg_q, addr: paddr_q, pmraddroff: pmr_q, mseccfg: msec_q};

endmodule
